// File: rtl/mdr_sequencer.sv
// mdr_sequencer: control FSM for the shared multiply/divide/sqrt iterative
// datapaths. It issues an operand-load strobe, counts the iterations and
// raises a final-iteration strobe. It then waits for the unit to finish and
// returns a ready pulse, or an error pulse on a reserved op or a timeout.
// Every output comes straight from a flop.
module mdr_sequencer #(
  parameter int DW  = 16,
  parameter int CW  = $clog2(DW) + 1,
  parameter int TMO = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [1:0]    i_op,
  input  logic          i_clear,
  input  logic          i_unit_ready,
  output logic [2:0]    o_sel,
  output logic          o_enable,
  output logic [CW-1:0] o_count,
  output logic          o_done,
  output logic          o_busy,
  output logic          o_ready,
  output logic          o_error
);

  // Wide enough to count up to TMO-1 WAIT cycles.
  localparam int WW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] limit, limit_next;
  logic [WW-1:0] wait_cnt, wait_next;
  logic [2:0]    sel_next;
  logic [CW-1:0] count_next;
  logic          enable_next, done_next, busy_next, ready_next, error_next;
  logic          timeout;

  // The last WAIT cycle that may pass without i_unit_ready.
  assign timeout = (state == S_WAIT) && !i_unit_ready && (wait_cnt == WW'(TMO - 1));

  // State and output registers. Reset clears everything without any pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      limit    <= '0;
      wait_cnt <= '0;
      o_sel    <= 3'b000;
      o_enable <= 1'b0;
      o_count  <= '0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      o_ready  <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      state    <= state_next;
      limit    <= limit_next;
      wait_cnt <= wait_next;
      o_sel    <= sel_next;
      o_enable <= enable_next;
      o_count  <= count_next;
      o_done   <= done_next;
      o_busy   <= busy_next;
      o_ready  <= ready_next;
      o_error  <= error_next;
    end
  end

  // Next-state logic. i_clear overrides every transition, including a start.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_start && (i_op != 2'b11)) state_next = S_LOAD;
      S_LOAD: state_next = S_RUN;
      S_RUN:  if (o_count == limit) state_next = S_DONE;
      S_DONE: state_next = S_WAIT;
      S_WAIT: if (i_unit_ready || timeout) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (i_clear) state_next = S_IDLE;
  end

  // Output and datapath values for the next cycle, derived from the
  // transition being taken so that every output lines up with its state.
  always_comb begin
    limit_next  = limit;
    sel_next    = o_sel;
    count_next  = '0;
    wait_next   = '0;
    enable_next = (state_next == S_LOAD);
    done_next   = (state_next == S_DONE);
    busy_next   = (state_next != S_IDLE);
    ready_next  = !i_clear && (state == S_WAIT) && i_unit_ready;
    error_next  = !i_clear &&
                  (((state == S_IDLE) && i_start && (i_op == 2'b11)) || timeout);

    // Latch the unit select and the iteration limit when an op is accepted.
    if ((state == S_IDLE) && (state_next == S_LOAD)) begin
      sel_next   = 3'b001 << i_op;
      limit_next = (i_op == 2'b10) ? CW'(DW / 2) : CW'(DW);
    end

    case (state_next)
      S_IDLE:  sel_next   = 3'b000;
      S_RUN:   count_next = o_count + CW'(1);
      S_DONE:  count_next = o_count;
      S_WAIT:  count_next = o_count;
      default: count_next = '0;
    endcase

    // Count WAIT cycles from zero on each entry into WAIT.
    if ((state == S_WAIT) && (state_next == S_WAIT)) wait_next = wait_cnt + WW'(1);
  end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Directed testbench for mdr_sequencer (DW=16, TMO=8). Each cycle it compares
// all outputs, packed as {sel, enable, count, done, busy, ready, error},
// against values worked out by hand from the cycle number.
module tb_mdr_sequencer;

  localparam int DW  = 16;
  localparam int CW  = $clog2(DW) + 1;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [1:0]    i_op = 2'b00;
  logic          i_clear = 1'b0;
  logic          i_unit_ready = 1'b0;
  logic [2:0]    o_sel;
  logic          o_enable;
  logic [CW-1:0] o_count;
  logic          o_done;
  logic          o_busy;
  logic          o_ready;
  logic          o_error;

  int n_vec = 0;
  int n_bad = 0;

  mdr_sequencer #(.DW(DW), .CW(CW), .TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_clear      (i_clear),
    .i_unit_ready (i_unit_ready),
    .o_sel        (o_sel),
    .o_enable     (o_enable),
    .o_count      (o_count),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_ready      (o_ready),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic [2:0] sel, input logic en,
                                       input logic [CW-1:0] cnt, input logic dn,
                                       input logic bsy, input logic rdy, input logic err);
    pack = {19'd0, sel, en, cnt, dn, bsy, rdy, err};
  endfunction

  function automatic logic [31:0] observed();
    observed = pack(o_sel, o_enable, o_count, o_done, o_busy, o_ready, o_error);
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%04h exp=%04h", tag, got, exp);
    end else begin
      $display("ok   %s = %04h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The caller has already raised i_start with i_op in the current cycle
  // (cycle 0). This task walks cycles 1..end and checks every output. It
  // returns in the cycle that carries o_ready (ur=1) or o_error (ur=0).
  task automatic run_op(input string name, input int n, input logic [2:0] sel, input logic ur);
    int last;
    logic [2:0] e_sel;
    logic [CW-1:0] e_cnt;
    i_unit_ready = ur;
    last = ur ? n + 4 : n + 3 + TMO;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (c == 1) i_start = 1'b0;
      e_sel = (c < last) ? sel : 3'b000;
      if (c == 1 || c == last) e_cnt = '0;
      else if (c <= n + 1)     e_cnt = CW'(c - 1);
      else                     e_cnt = CW'(n);
      check_vec($sformatf("%s c%0d", name, c), observed(),
                pack(e_sel, c == 1, e_cnt, c == n + 2, c < last,
                     ur && c == last, !ur && c == last));
    end
  endtask

  initial begin
    // Outputs while reset is held.
    #2;
    check_vec("reset_async", observed(), 32'd0);
    tick();
    tick();
    check_vec("reset_hold", observed(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_vec("idle_after_reset", observed(), 32'd0);

    // Multiply with i_unit_ready tied high.
    i_start = 1'b1; i_op = 2'b00;
    run_op("mult", DW, 3'b001, 1'b1);

    // Sqrt, then a divide issued back-to-back in the o_ready cycle.
    i_start = 1'b1; i_op = 2'b10;
    run_op("sqrt", DW / 2, 3'b100, 1'b1);
    i_start = 1'b1; i_op = 2'b01;
    run_op("div_b2b", DW, 3'b010, 1'b1);

    // Reserved op: only an error pulse, the FSM never leaves IDLE.
    i_start = 1'b1; i_op = 2'b11;
    tick();
    i_start = 1'b0;
    check_vec("reserved c1", observed(), pack(3'b000, 0, '0, 0, 0, 0, 1));
    tick();
    check_vec("reserved c2", observed(), 32'd0);

    // Timeout: the unit never reports completion.
    i_start = 1'b1; i_op = 2'b00;
    run_op("timeout", DW, 3'b001, 1'b0);
    tick();
    check_vec("timeout_after", observed(), 32'd0);

    // Abort: i_clear and i_start both high in cycle 10 of a multiply.
    i_unit_ready = 1'b1;
    i_start = 1'b1; i_op = 2'b00;
    tick();
    i_start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    check_vec("abort c10", observed(), pack(3'b001, 0, CW'(9), 0, 1, 0, 0));
    i_clear = 1'b1; i_start = 1'b1;
    tick();
    i_clear = 1'b0; i_start = 1'b0;
    check_vec("abort c11", observed(), 32'd0);
    for (int c = 12; c <= 32; c += 4) begin
      tick(); tick(); tick(); tick();
      check_vec($sformatf("abort_idle c%0d", c + 3), observed(), 32'd0);
    end

    // Async reset mid-RUN at count 7, then a fresh multiply.
    i_start = 1'b1; i_op = 2'b00;
    tick();
    i_start = 1'b0;
    for (int c = 2; c <= 8; c++) tick();
    check_vec("pre_reset c8", observed(), pack(3'b001, 0, CW'(7), 0, 1, 0, 0));
    rst = 1'b0;
    #1;
    check_vec("async_reset", observed(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_vec("after_reset", observed(), 32'd0);
    i_start = 1'b1; i_op = 2'b00;
    run_op("mult_restart", DW, 3'b001, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdr_sequencer.md
# mdr_sequencer

Control FSM that sequences the shared multiply/divide/square-root (MDR) iterative datapaths. It accepts one operation request at a time and issues the one-cycle operand-load enable. It then generates the iteration count and final-iteration `done` strobe the selected unit consumes. When the unit's final-product stage reports completion, it returns a one-cycle result-ready pulse to the requester. It sits between the system front end and the multiplication, division and square-root units, which share one ALU.

## Interface
- `DW`, 16, operand data width; sets multiply/divide iteration count (DW) and sqrt iteration count (DW/2); even, ≥4
- `CW`, $clog2(DW)+1, iteration counter width (must represent DW)
- `TMO`, 8, max cycles spent waiting for unit completion before error
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  operation request, sampled only in IDLE
- `i_op`  in  2  00 multiply, 01 divide, 10 sqrt, 11 reserved
- `i_clear`  in  1  synchronous abort, highest priority after reset
- `i_unit_ready`  in  1  selected unit's final-product stage has captured result
- `o_sel`  out  3  one-hot unit select {sqrt, div, mult}; 000 when idle
- `o_enable`  out  1  operand-load strobe to selected unit
- `o_count`  out  CW  current iteration index
- `o_done`  out  1  last-iteration-complete strobe to selected unit
- `o_busy`  out  1  high whenever state ≠ IDLE
- `o_ready`  out  1  one-cycle result-valid pulse to requester
- `o_error`  out  1  one-cycle pulse: reserved op or completion timeout

## Operation
- States: IDLE, LOAD, RUN, DONE, WAIT. All outputs registered.
- IDLE:
  - `i_start`=1 with `i_op`≠11 → LOAD. Latch `o_sel` from `i_op`. Latch iteration limit N (DW for mult/div, DW/2 for sqrt).
  - `i_start`=1 with `i_op`=11 → pulse `o_error` next cycle, stay IDLE.
- LOAD (1 cycle): `o_enable`=1, `o_count`=0 → RUN.
- RUN (N cycles): `o_count` increments 1..N, one per cycle. After the cycle with `o_count`=N → DONE.
- DONE (1 cycle): `o_done`=1, `o_count` holds N → WAIT.
- WAIT:
  - `i_unit_ready`=1 → IDLE, with `o_ready`=1 in the first IDLE cycle.
  - Internal wait counter reaches TMO cycles without `i_unit_ready` → IDLE, with `o_error`=1 in the first IDLE cycle and no `o_ready`.
- `o_sel` holds from LOAD through WAIT. It is 000 in IDLE. `o_count` returns to 0 in IDLE.
- `i_start` outside IDLE is ignored; no queueing.
- `i_clear`=1 in any state → IDLE next cycle. All outputs go to 0, no `o_ready`, no `o_error`. `i_clear` wins over a simultaneous `i_start`.
- `i_unit_ready` is ignored outside WAIT.

## Timing
- Reset (`rst`=0, async): state IDLE. `o_sel`=000, `o_count`=0. `o_enable`, `o_done`, `o_busy`, `o_ready`, `o_error` all 0. Reset mid-operation aborts without any pulse.
- With `i_start` sampled high in cycle 0, mult/div, DW=16:
  - LOAD in cycle 1
  - RUN in cycles 2..17 (`o_count` 1..16)
  - DONE in cycle 18
  - WAIT from cycle 19
- If `i_unit_ready`=1 in cycle 19, `o_ready` is high in cycle 20. Minimum start-to-ready latency is N+4 cycles.
- The IDLE cycle carrying `o_ready` or `o_error` accepts a new `i_start`, giving back-to-back issue. `o_busy` rises in the next cycle.
- Timeout: TMO WAIT cycles without `i_unit_ready`, then `o_error` in the following cycle. For DW=16 mult, TMO=8: WAIT is cycles 19..26, `o_error` is in cycle 27.
- `o_enable`, `o_done`, `o_ready` and `o_error` are each exactly one cycle wide.

## Test plan
- Mult, DW=16: `i_start`=1, `i_op`=00 in cycle 0; `i_unit_ready` tied high.
  → `o_sel`=001 from cycle 1; `o_enable` in cycle 1; `o_count` 1..16 in cycles 2–17; `o_done` in cycle 18; `o_ready` in cycle 20; `o_busy` cycles 1–19.
- Sqrt: `i_op`=10 → `o_sel`=100; `o_count` 1..8; `o_done` in cycle 10; `o_ready` in cycle 12. A second `i_start` (div) in cycle 12 → LOAD in cycle 13.
- Reserved op: `i_op`=11 with `i_start` → `o_error` in cycle 1; `o_busy`, `o_enable` and `o_sel` stay 0.
- Timeout: mult with `i_unit_ready`=0 throughout → `o_error` in cycle 27, `o_ready` never asserted, IDLE in cycle 27.
- Abort: `i_clear` and `i_start` both high in cycle 10 of a mult → all outputs 0 in cycle 11, no LOAD in cycle 11, no `o_ready`/`o_error`.
- Async reset: drop `rst` mid-RUN at `o_count`=7 → outputs 0 immediately. After release, a fresh mult restarts `o_count` from 0.
